// File: rtl/cart_pkg.sv
// Shared tag codes, LED decode values and FSM state encoding for the RFID cart controller.
package cart_pkg;

    localparam logic [7:0] TAG_A = 8'd17;
    localparam logic [7:0] TAG_B = 8'd9;

    localparam logic [2:0] LED_DEC_A   = 3'b001;
    localparam logic [2:0] LED_DEC_B   = 3'b010;
    localparam logic [2:0] LED_DEC_UNK = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        NOTIFY = 2'd2
    } cart_state_t;

    function automatic logic [2:0] tag_code(input logic [7:0] tag);
        logic [2:0] code;
        code = LED_DEC_UNK;
        if (tag == TAG_A)
            code = LED_DEC_A;
        else if (tag == TAG_B)
            code = LED_DEC_B;
        return code;
    endfunction

endpackage

// File: rtl/rfid_holdoff_timer.sv
// Loadable down-counter that stops at zero; used for the same-tag hold-off window
// and, when ACK_TIMEOUT_EN is defined, for the acknowledge timeout.
module rfid_holdoff_timer #(
    parameter int unsigned LOAD_VAL = 24_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int unsigned W = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst)
            count_reg <= '0;
        else if (load)
            count_reg <= W'(LOAD_VAL);
        else if (count_reg != '0)
            count_reg <= count_reg - W'(1);
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/rfid_cart_ctrl.sv
// RFID tag byte sequencer: filters repeated reads, keeps per-item counts, drives LEDs and
// hands events to the buzzer/display over req/ack. Define ACK_TIMEOUT_EN to bound the ack wait.
module rfid_cart_ctrl
    import cart_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 24_000_000,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned ACK_TIMEOUT = 2_400_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             mode_remove,
    output logic [7:0]       led,
    output logic [2:0]       led_dec,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             evt_req,
    input  logic             evt_ack,
    output logic             err
);

    cart_state_t      state_reg;
    logic [7:0]       byte_reg;
    logic [7:0]       last_reg;
    logic [7:0]       led_reg;
    logic [2:0]       led_dec_reg;
    logic [CNT_W-1:0] cnt_a_reg;
    logic [CNT_W-1:0] cnt_b_reg;
    logic             evt_req_reg;
    logic             err_reg;

    logic             hold_zero;
    logic             ack_expired;
    logic             known;
    logic             is_a;
    logic             accept;
    logic             enter_notify;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_err;

    always_comb begin
        known    = (byte_reg == TAG_A) || (byte_reg == TAG_B);
        is_a     = (byte_reg == TAG_A);
        // A repeat read of the last accepted tag is only ignored while the window is open.
        accept   = known && !((byte_reg == last_reg) && !hold_zero);
        cur_cnt  = is_a ? cnt_a_reg : cnt_b_reg;
        cnt_next = cur_cnt;
        cnt_err  = 1'b0;
        if (mode_remove) begin
            if (cur_cnt == '0)
                cnt_err = 1'b1;
            else
                cnt_next = cur_cnt - CNT_W'(1);
        end else begin
            if (cur_cnt == '1)
                cnt_err = 1'b1;
            else
                cnt_next = cur_cnt + CNT_W'(1);
        end
        enter_notify = (state_reg == CHECK) && accept;
    end

    rfid_holdoff_timer #(
        .LOAD_VAL (HOLD_CYCLES)
    ) u_holdoff (
        .clk  (clk),
        .rst  (rst),
        .load (enter_notify),
        .zero (hold_zero)
    );

`ifdef ACK_TIMEOUT_EN
    // Loaded one short so the timer reaches zero ACK_TIMEOUT cycles after NOTIFY entry.
    rfid_holdoff_timer #(
        .LOAD_VAL (ACK_TIMEOUT - 1)
    ) u_ack_timer (
        .clk  (clk),
        .rst  (rst),
        .load (enter_notify),
        .zero (ack_expired)
    );
`else
    // NOTIFY waits indefinitely; this folds to a constant 0.
    assign ack_expired = (ACK_TIMEOUT == 0) && 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            byte_reg    <= '0;
            last_reg    <= '0;
            led_reg     <= '0;
            led_dec_reg <= '0;
            cnt_a_reg   <= '0;
            cnt_b_reg   <= '0;
            evt_req_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rx_valid && (rx_data != 8'd0)) begin
                        byte_reg  <= rx_data;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    state_reg <= IDLE;
                    if (!known) begin
                        led_dec_reg <= LED_DEC_UNK;
                        err_reg     <= 1'b1;
                    end else if (accept) begin
                        if (is_a)
                            cnt_a_reg <= cnt_next;
                        else
                            cnt_b_reg <= cnt_next;
                        err_reg     <= cnt_err;
                        led_reg     <= byte_reg;
                        led_dec_reg <= tag_code(byte_reg);
                        last_reg    <= byte_reg;
                        evt_req_reg <= 1'b1;
                        state_reg   <= NOTIFY;
                    end
                end
                NOTIFY: begin
                    if (evt_ack) begin
                        evt_req_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end else if (ack_expired) begin
                        evt_req_reg <= 1'b0;
                        err_reg     <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign led     = led_reg;
    assign led_dec = led_dec_reg;
    assign cnt_a   = cnt_a_reg;
    assign cnt_b   = cnt_b_reg;
    assign evt_req = evt_req_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_rfid_cart_ctrl.sv
// Self-checking bench for rfid_cart_ctrl: directed scenarios plus randomized traffic against
// an event-level reference model (timeout scenario only when ACK_TIMEOUT_EN is defined).
module tb_rfid_cart_ctrl;

    localparam int H   = 200;
    localparam int CW  = 4;
    localparam int AT  = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          mode_remove = 1'b0;
    logic          evt_ack = 1'b0;
    logic [7:0]    led;
    logic [2:0]    led_dec;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic          evt_req;
    logic          err;

    rfid_cart_ctrl #(
        .HOLD_CYCLES (H),
        .CNT_W       (CW),
        .ACK_TIMEOUT (AT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .mode_remove (mode_remove),
        .led         (led),
        .led_dec     (led_dec),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b),
        .evt_req     (evt_req),
        .evt_ack     (evt_ack),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Reference model: cart contents and the time of the last accepted event.
    logic [7:0] m_led, m_last;
    logic [2:0] m_dec;
    int         m_a, m_b, m_acc;
    logic       e_err, e_req;

    wire [20:0] dut_vec = {led, led_dec, cnt_a, cnt_b, evt_req, err};

    function automatic logic [20:0] exp_vec();
        return {m_led, m_dec, CW'(m_a), CW'(m_b), e_req, e_err};
    endfunction

    task automatic model_reset();
        m_led = '0; m_last = '0; m_dec = '0;
        m_a = 0; m_b = 0; m_acc = -1000000;
        e_err = 1'b0; e_req = 1'b0;
    endtask

    task automatic model_rx(input logic [7:0] tag, input logic rm, input int cap);
        int c;
        e_err = 1'b0;
        e_req = 1'b0;
        if (tag != 8'd17 && tag != 8'd9) begin
            m_dec = 3'b100;
            e_err = 1'b1;
            return;
        end
        if (tag == m_last && (cap - m_acc) < H)
            return;
        c = (tag == 8'd17) ? m_a : m_b;
        if (!rm) begin
            if (c < MAXC) c++; else e_err = 1'b1;
        end else begin
            if (c > 0) c--; else e_err = 1'b1;
        end
        if (tag == 8'd17) m_a = c; else m_b = c;
        m_led  = tag;
        m_dec  = (tag == 8'd17) ? 3'b001 : 3'b010;
        m_last = tag;
        m_acc  = cap + 1;
        e_req  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0; evt_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Returns at the negedge after the CHECK edge; cap is the capture edge index.
    task automatic send(input logic [7:0] b, input logic rm, output int cap);
        @(negedge clk);
        mode_remove = rm; rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        cap = cyc;
        @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
        e_req = 1'b0;
        e_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== 21'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec, 21'd0);
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_add_and_ack();
        int cap;
        send(8'd17, 1'b0, cap);
        model_rx(8'd17, 1'b0, cap);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL add_17 got=%h exp=%h", dut_vec, exp_vec());
        end
        ack();
        checks++;
        if (evt_req !== 1'b0) begin
            failures++;
            $display("FAIL ack_drop evt_req got=%b exp=0", evt_req);
        end
    endtask

    task automatic test_holdoff();
        int cap;
        repeat (100) @(negedge clk);
        send(8'd17, 1'b0, cap);
        model_rx(8'd17, 1'b0, cap);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL repeat_dropped got=%h exp=%h", dut_vec, exp_vec());
        end
        repeat (H) @(negedge clk);
        send(8'd17, 1'b0, cap);
        model_rx(8'd17, 1'b0, cap);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL repeat_after_window got=%h exp=%h", dut_vec, exp_vec());
        end
        ack();
        // Window edge: H-1 cycles after acceptance is still blocked, H cycles is not.
        send(8'd9, 1'b0, cap);
        model_rx(8'd9, 1'b0, cap);
        ack();
        repeat (H - 5) @(negedge clk);
        send(8'd9, 1'b0, cap);
        model_rx(8'd9, 1'b0, cap);
        checks++;
        if (dut_vec !== exp_vec() || e_req !== 1'b0) begin
            failures++;
            $display("FAIL window_last_cycle got=%h exp=%h", dut_vec, exp_vec());
        end
        do_reset();
        send(8'd9, 1'b0, cap);
        model_rx(8'd9, 1'b0, cap);
        ack();
        repeat (H - 4) @(negedge clk);
        send(8'd9, 1'b0, cap);
        model_rx(8'd9, 1'b0, cap);
        checks++;
        if (dut_vec !== exp_vec() || e_req !== 1'b1) begin
            failures++;
            $display("FAIL window_expired got=%h exp=%h", dut_vec, exp_vec());
        end
        ack();
    endtask

    task automatic test_switch_tag();
        int cap;
        do_reset();
        send(8'd17, 1'b0, cap);
        model_rx(8'd17, 1'b0, cap);
        ack();
        send(8'd9, 1'b0, cap);
        model_rx(8'd9, 1'b0, cap);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL switch_tag got=%h exp=%h", dut_vec, exp_vec());
        end
        ack();
    endtask

    task automatic test_limits();
        int cap;
        do_reset();
        send(8'd9, 1'b1, cap);
        model_rx(8'd9, 1'b1, cap);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL underflow got=%h exp=%h", dut_vec, exp_vec());
        end
        ack();
        for (int i = 0; i < MAXC + 1; i++) begin
            send(8'd17, 1'b0, cap);
            model_rx(8'd17, 1'b0, cap);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL fill_a[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
            end
            ack();
            send(8'd9, 1'b0, cap);
            model_rx(8'd9, 1'b0, cap);
            ack();
        end
    endtask

    task automatic test_unknown_and_notify();
        int cap;
        send(8'd5, 1'b0, cap);
        model_rx(8'd5, 1'b0, cap);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL unknown_tag got=%h exp=%h", dut_vec, exp_vec());
        end
        send(8'd17, 1'b1, cap);
        model_rx(8'd17, 1'b1, cap);
        // Bytes offered during NOTIFY, including on the ack cycle, must vanish.
        @(negedge clk);
        rx_data = 8'd9; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        evt_ack = 1'b1; rx_valid = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0; rx_valid = 1'b0;
        e_req = 1'b0; e_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL notify_drop got=%h exp=%h", dut_vec, exp_vec());
        end
        send(8'd9, 1'b0, cap);
        model_rx(8'd9, 1'b0, cap);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        checks++;
        if (dut_vec !== 21'd0) begin
            failures++;
            $display("FAIL reset_mid_handshake got=%h exp=%h", dut_vec, 21'd0);
        end
    endtask

    task automatic test_random();
        int cap, sel, gap;
        logic [7:0] tag;
        logic rm;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 5);
            if (sel < 2)       tag = 8'd17;
            else if (sel < 4)  tag = 8'd9;
            else if (sel == 4) tag = 8'd5;
            else               tag = 8'($urandom_range(1, 255));
            rm  = ($urandom_range(0, 2) == 0);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 260) : $urandom_range(0, 20);
            repeat (gap) @(negedge clk);
            send(tag, rm, cap);
            model_rx(tag, rm, cap);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random[%0d] tag=%0d rm=%b got=%h exp=%h", i, tag, rm, dut_vec, exp_vec());
            end
            if (e_req) begin
                ack();
                checks++;
                if (evt_req !== 1'b0) begin
                    failures++;
                    $display("FAIL random_ack[%0d] evt_req got=%b exp=0", i, evt_req);
                end
            end
        end
    endtask

`ifdef ACK_TIMEOUT_EN
    task automatic test_ack_timeout();
        int cap;
        do_reset();
        send(8'd17, 1'b0, cap);
        model_rx(8'd17, 1'b0, cap);
        for (int k = 1; k < AT; k++) begin
            @(negedge clk);
            checks++;
            if (evt_req !== 1'b1 || err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait[%0d] req/err got=%b%b exp=10", k, evt_req, err);
            end
        end
        @(negedge clk);
        e_req = 1'b0;
        e_err = 1'b1;
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL ack_timeout got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_add_and_ack();
        test_holdoff();
        test_switch_tag();
        test_limits();
        test_unknown_and_notify();
        test_random();
`ifdef ACK_TIMEOUT_EN
        test_ack_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
